// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a single shared combinational ALU.
// One transaction in flight at a time: IDLE accept, EXEC capture, RESP hold.
module alu_arbiter #(
  parameter int DWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req_valid_i,
  output logic [1:0]        req_ready_o,
  input  logic [1:0]        req0_sel_i,
  input  logic [1:0]        req1_sel_i,
  input  logic [DWIDTH-1:0] req0_op1_i,
  input  logic [DWIDTH-1:0] req0_op2_i,
  input  logic [DWIDTH-1:0] req1_op1_i,
  input  logic [DWIDTH-1:0] req1_op2_i,
  output logic [1:0]        alu_sel_o,
  output logic [DWIDTH-1:0] alu_op1_o,
  output logic [DWIDTH-1:0] alu_op2_o,
  input  logic [DWIDTH-1:0] alu_res_i,
  output logic              rsp_valid_o,
  output logic              rsp_id_o,
  output logic [DWIDTH-1:0] rsp_data_o,
  input  logic              rsp_ready_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic              r_last;
  logic              r_id;
  logic [1:0]        r_sel;
  logic [DWIDTH-1:0] r_op1;
  logic [DWIDTH-1:0] r_op2;
  logic [DWIDTH-1:0] r_data;
  logic              w_any;
  logic              w_gnt_id;
  logic              w_accept;

  assign w_any    = |req_valid_i;
  // On a tie the requester not served last wins; a lone request always wins.
  assign w_gnt_id = (&req_valid_i) ? ~r_last : req_valid_i[1];
  assign w_accept = (r_state == IDLE) && w_any;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_any ? EXEC : IDLE;
      EXEC:    w_next = RESP;
      RESP:    w_next = rsp_ready_i ? IDLE : RESP;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    req_ready_o = 2'b00;
    rsp_valid_o = 1'b0;
    if (w_accept && rst) begin
      req_ready_o = w_gnt_id ? 2'b10 : 2'b01;
    end
    if (r_state == RESP) begin
      rsp_valid_o = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last <= 1'b1;
      r_id   <= 1'b0;
      r_sel  <= '0;
      r_op1  <= '0;
      r_op2  <= '0;
    end else if (w_accept) begin
      r_last <= w_gnt_id;
      r_id   <= w_gnt_id;
      r_sel  <= w_gnt_id ? req1_sel_i : req0_sel_i;
      r_op1  <= w_gnt_id ? req1_op1_i : req0_op1_i;
      r_op2  <= w_gnt_id ? req1_op2_i : req0_op2_i;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_data <= '0;
    end else if (r_state == EXEC) begin
      r_data <= alu_res_i;
    end
  end

  assign alu_sel_o  = r_sel;
  assign alu_op1_o  = r_op1;
  assign alu_op2_o  = r_op2;
  assign rsp_id_o   = r_id;
  assign rsp_data_o = r_data;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: transaction-level reference checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_alu_arbiter;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [1:0]    req_valid_i = '0;
  logic [1:0]    req_ready_o;
  logic [1:0]    req0_sel_i = '0;
  logic [1:0]    req1_sel_i = '0;
  logic [DW-1:0] req0_op1_i = '0;
  logic [DW-1:0] req0_op2_i = '0;
  logic [DW-1:0] req1_op1_i = '0;
  logic [DW-1:0] req1_op2_i = '0;
  logic [1:0]    alu_sel_o;
  logic [DW-1:0] alu_op1_o;
  logic [DW-1:0] alu_op2_o;
  logic [DW-1:0] alu_res_i;
  logic          rsp_valid_o;
  logic          rsp_id_o;
  logic [DW-1:0] rsp_data_o;
  logic          rsp_ready_i = 1'b1;

  int total = 0;
  int bad   = 0;

  alu_arbiter #(.DWIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req0_sel_i(req0_sel_i), .req1_sel_i(req1_sel_i),
    .req0_op1_i(req0_op1_i), .req0_op2_i(req0_op2_i),
    .req1_op1_i(req1_op1_i), .req1_op2_i(req1_op2_i),
    .alu_sel_o(alu_sel_o), .alu_op1_o(alu_op1_o), .alu_op2_o(alu_op2_o),
    .alu_res_i(alu_res_i),
    .rsp_valid_o(rsp_valid_o), .rsp_id_o(rsp_id_o), .rsp_data_o(rsp_data_o),
    .rsp_ready_i(rsp_ready_i)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] alu_f(logic [1:0] s, logic [DW-1:0] a, logic [DW-1:0] b);
    case (s)
      2'd0:    return a + b;
      2'd1:    return a - b;
      2'd2:    return a & b;
      default: return a | b;
    endcase
  endfunction

  assign alu_res_i = alu_f(alu_sel_o, alu_op1_o, alu_op2_o);

  task automatic chk(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference: who is served next, and what the one transaction in flight looks like.
  function automatic logic pick(logic [1:0] v, logic last);
    if (v == 2'b11) return !last;
    return v[1];
  endfunction

  logic          m_busy, m_last, m_id;
  int            m_age;
  logic [1:0]    m_sel;
  logic [DW-1:0] m_op1, m_op2, m_data;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_busy <= 1'b0; m_age <= 0; m_last <= 1'b1; m_id <= 1'b0;
      m_sel <= '0; m_op1 <= '0; m_op2 <= '0; m_data <= '0;
    end else if (!m_busy) begin
      if (req_valid_i != 2'b00) begin
        m_busy <= 1'b1;
        m_age  <= 0;
        m_id   <= pick(req_valid_i, m_last);
        m_last <= pick(req_valid_i, m_last);
        m_sel  <= pick(req_valid_i, m_last) ? req1_sel_i : req0_sel_i;
        m_op1  <= pick(req_valid_i, m_last) ? req1_op1_i : req0_op1_i;
        m_op2  <= pick(req_valid_i, m_last) ? req1_op2_i : req0_op2_i;
      end
    end else if (m_age == 0) begin
      m_age  <= 1;
      m_data <= alu_f(m_sel, m_op1, m_op2);
    end else if (rsp_ready_i) begin
      m_busy <= 1'b0;
    end
  end

  always @(negedge clk) begin
    logic [1:0] exp_ready;
    exp_ready = 2'b00;
    if (rst && !m_busy && req_valid_i != 2'b00)
      exp_ready = pick(req_valid_i, m_last) ? 2'b10 : 2'b01;
    chk("m_req_ready", 32'(req_ready_o), 32'(exp_ready));
    chk("m_rsp_valid", 32'(rsp_valid_o), 32'(m_busy && m_age == 1));
    chk("m_rsp_id", 32'(rsp_id_o), 32'(m_id));
    chk("m_rsp_data", rsp_data_o, m_data);
    chk("m_alu_sel", 32'(alu_sel_o), 32'(m_sel));
    chk("m_alu_op1", alu_op1_o, m_op1);
    chk("m_alu_op2", alu_op2_o, m_op2);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #60000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int gq[$];
    int gt[$];
    int rq[$];
    logic [DW-1:0] rd[$];
    logic [DW-1:0] res_s;

    // Reset: ready gated off even with requests present.
    req_valid_i = 2'b11;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 32'(req_ready_o), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
    chk("rst_rsp_data", rsp_data_o, 32'd0);
    req_valid_i = 2'b00;
    tick();
    rst = 1'b1;

    // Single request from requester 0: 5 + 7.
    req_valid_i = 2'b01; req0_sel_i = 2'd0; req0_op1_i = 5; req0_op2_i = 7;
    #1 chk("single_ready", 32'(req_ready_o), 32'b01);
    tick();
    req_valid_i = 2'b00;
    #1 chk("single_exec_valid", 32'(rsp_valid_o), 32'd0);
    chk("single_exec_op1", alu_op1_o, 32'd5);
    tick();
    #1 chk("single_rsp_valid", 32'(rsp_valid_o), 32'd1);
    chk("single_rsp_id", 32'(rsp_id_o), 32'd0);
    chk("single_rsp_data", rsp_data_o, 32'd12);
    tick();
    #1 chk("single_back_idle", 32'(rsp_valid_o), 32'd0);

    // Fresh reset, then a continuous tie.
    #1 rst = 1'b0;
    tick();
    rst = 1'b1;
    req_valid_i = 2'b11;
    req0_sel_i = 2'd0; req0_op1_i = 1;  req0_op2_i = 2;
    req1_sel_i = 2'd1; req1_op1_i = 10; req1_op2_i = 3;
    for (int c = 0; c < 14; c++) begin
      #1;
      if (req_ready_o != 2'b00) begin
        gq.push_back(int'(req_ready_o[1]));
        gt.push_back(c);
      end
      if (rsp_valid_o) begin
        rq.push_back(int'(rsp_id_o));
        rd.push_back(rsp_data_o);
      end
      tick();
      if (gq.size() >= 4) req_valid_i = 2'b00;
    end
    chk("tie_grant_count", 32'(gq.size()), 32'd4);
    chk("tie_rsp_count", 32'(rq.size()), 32'd4);
    if (gq.size() >= 4 && rq.size() >= 4) begin
      for (int k = 0; k < 4; k++) begin
        chk("tie_grant_id", 32'(gq[k]), 32'(k % 2));
        chk("tie_rsp_id", 32'(rq[k]), 32'(k % 2));
      end
      for (int k = 1; k < 4; k++) chk("tie_interval", 32'(gt[k] - gt[k-1]), 32'd3);
      chk("tie_data0", rd[0], 32'd3);
      chk("tie_data1", rd[1], 32'd7);
    end

    // Backpressure: F0F0 & FF00 held for five cycles.
    rsp_ready_i = 1'b0;
    req_valid_i = 2'b01; req0_sel_i = 2'd2; req0_op1_i = 32'hF0F0; req0_op2_i = 32'hFF00;
    tick();
    req_valid_i = 2'b00;
    tick();
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_valid", 32'(rsp_valid_o), 32'd1);
      chk("bp_id", 32'(rsp_id_o), 32'd0);
      chk("bp_data", rsp_data_o, 32'hF000);
      chk("bp_ready", 32'(req_ready_o), 32'd0);
      tick();
    end
    rsp_ready_i = 1'b1;
    #1 chk("bp_still_valid", 32'(rsp_valid_o), 32'd1);
    tick();
    #1 chk("bp_release_idle", 32'(rsp_valid_o), 32'd0);
    chk("bp_data_kept", rsp_data_o, 32'hF000);

    // Requester 1 raised while requester 0 is busy.
    tick();
    req_valid_i = 2'b01; req0_sel_i = 2'd0; req0_op1_i = 3; req0_op2_i = 4;
    tick();
    req_valid_i = 2'b10; req1_sel_i = 2'd1; req1_op1_i = 100; req1_op2_i = 1;
    #1 chk("pend_exec_ready", 32'(req_ready_o), 32'd0);
    tick();
    #1 chk("pend_resp_ready", 32'(req_ready_o), 32'd0);
    chk("pend_resp_data", rsp_data_o, 32'd7);
    tick();
    #1 chk("pend_idle_ready", 32'(req_ready_o), 32'b10);
    tick();
    req_valid_i = 2'b00;
    tick();
    #1 chk("pend_rsp_id", 32'(rsp_id_o), 32'd1);
    chk("pend_rsp_data", rsp_data_o, 32'd99);

    // Operand forwarding with all-ones operand.
    tick();
    req_valid_i = 2'b10; req1_sel_i = 2'b11; req1_op1_i = 32'hFFFF_FFFF; req1_op2_i = 32'h1;
    tick();
    req_valid_i = 2'b00;
    #1 chk("fwd_sel", 32'(alu_sel_o), 32'd3);
    chk("fwd_op1", alu_op1_o, 32'hFFFF_FFFF);
    chk("fwd_op2", alu_op2_o, 32'h1);
    res_s = alu_res_i;
    rsp_ready_i = 1'b0;
    tick();
    #1 chk("fwd_rsp_data", rsp_data_o, 32'hFFFF_FFFF);
    chk("fwd_rsp_eq_res", rsp_data_o, res_s);

    // Reset while a response is being held.
    #1 rst = 1'b0;
    #1;
    chk("rr_valid", 32'(rsp_valid_o), 32'd0);
    chk("rr_id", 32'(rsp_id_o), 32'd0);
    chk("rr_data", rsp_data_o, 32'd0);
    chk("rr_op1", alu_op1_o, 32'd0);
    chk("rr_sel", 32'(alu_sel_o), 32'd0);
    tick();
    rst = 1'b1;
    rsp_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1 chk("rr_no_rsp", 32'(rsp_valid_o), 32'd0);
      tick();
    end
    req_valid_i = 2'b11;
    #1 chk("rr_first_tie", 32'(req_ready_o), 32'b01);
    tick();
    req_valid_i = 2'b00;
    repeat (4) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
